// File: rtl/vga_pkg.sv
// Shared encodings and reset constants for the VGA pattern engine.
// Register map, pattern modes, LFSR seed and the noise-generator step function.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_NOISE    = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    REG_MODE  = 2'd0,
    REG_FG    = 2'd1,
    REG_BG    = 2'd2,
    REG_SHIFT = 2'd3
  } reg_addr_e;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [2:0]  SHIFT_DEFAULT = 3'd3;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit 15 is tap 16).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/vga_pattern_engine_if.sv
// Configuration write bus of the VGA pattern engine.
// The host drives through master; the engine receives through slave.
interface vga_pattern_engine_if;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_data;

  modport master (output cfg_wr, cfg_addr, cfg_data);
  modport slave  (input  cfg_wr, cfg_addr, cfg_data);
endinterface

// File: rtl/vga_timing_core.sv
// Raster counters for the VGA pattern engine: position, sync windows,
// active-video flag and the end-of-frame commit strobe (all from counter state).
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          active,
  output logic          commit
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // NOTE: clocked state uses <= so every flop samples pre-edge values;
  // a blocking = here would let later statements see already-updated counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
    end else begin
      hcount <= hcount + HW'(1);
    end
  end

  assign hsync_on = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
  assign vsync_on = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
  assign active   = (hcount < H_VIS) && (vcount < V_VIS);
  assign commit   = (hcount == H_LAST) && (vcount == V_LAST);

endmodule

// File: rtl/vga_pattern_engine.sv
// VGA test-pattern generator: double-buffered config registers committed at
// frame end, four pattern modes, and registered sync/de/rgb with one cycle latency.
module vga_pattern_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CBITS    = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_pattern_engine_if.slave   cfg,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic [3*CBITS-1:0]    rgb,
  output logic                  frame_tick
);
  import vga_pkg::*;

  localparam int CW = 3 * CBITS;
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  typedef struct packed {
    mode_e          mode;
    logic [CW-1:0]  fg;
    logic [CW-1:0]  bg;
    logic [2:0]     shift;
  } regs_t;

  localparam regs_t REGS_RESET = '{mode: MODE_SOLID, fg: '0, bg: '0, shift: SHIFT_DEFAULT};

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hsync_on, vsync_on, active, commit;

  regs_t         pend_q, act_q;
  logic [15:0]   lfsr_q;
  logic [HW-1:0] hsh;
  logic [VW-1:0] vsh;
  logic [CW-1:0] pix;

  vga_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .hcount   (hcount),
    .vcount   (vcount),
    .hsync_on (hsync_on),
    .vsync_on (vsync_on),
    .active   (active),
    .commit   (commit)
  );

  // NOTE: pix gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    hsh = hcount >> act_q.shift;
    vsh = vcount >> act_q.shift;
    pix = '0;
    if (active) begin
      case (act_q.mode)
        MODE_SOLID:    pix = act_q.fg;
        MODE_NOISE:    pix = lfsr_q[CW-1:0];
        MODE_CHECKER:  pix = (hsh[0] ^ vsh[0]) ? act_q.fg : act_q.bg;
        MODE_GRADIENT: pix = {3{hsh[CBITS-1:0]}};
      endcase
    end
  end

  // NOTE: the config registers are a handful of flops, not a memory array,
  // so they are reset along with the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= REGS_RESET;
      act_q      <= REGS_RESET;
      lfsr_q     <= LFSR_SEED;
      hs         <= ~SYNC_POL;
      vs         <= ~SYNC_POL;
      de         <= 1'b0;
      rgb        <= '0;
      frame_tick <= 1'b0;
    end else begin
      // A write on the commit cycle lands in pending only; act_q takes the old value.
      if (commit) act_q <= pend_q;
      if (cfg.cfg_wr) begin
        case (reg_addr_e'(cfg.cfg_addr))
          REG_MODE:  pend_q.mode  <= mode_e'(cfg.cfg_data[1:0]);
          REG_FG:    pend_q.fg    <= cfg.cfg_data[CW-1:0];
          REG_BG:    pend_q.bg    <= cfg.cfg_data[CW-1:0];
          REG_SHIFT: pend_q.shift <= cfg.cfg_data[2:0];
        endcase
      end
      if (active) lfsr_q <= lfsr_next(lfsr_q);
      hs         <= hsync_on ? SYNC_POL : ~SYNC_POL;
      vs         <= vsync_on ? SYNC_POL : ~SYNC_POL;
      de         <= active;
      rgb        <= pix;
      frame_tick <= commit;
    end
  end

  // Bits of the bus and shifted counters that the patterns never look at.
  logic unused_bits;
  assign unused_bits = ^{cfg.cfg_data, hsh, vsh};

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Scoreboarded bench for vga_pattern_engine on a reduced raster (24x17 clocks)
// with directed checks of timing, deferred commit, collision, patterns and reset.
module tb_vga_pattern_engine;

  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 12, VF = 1, VSY = 2, VB = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs, vs, de, ft;
  logic [5:0] rgb;

  vga_pattern_engine_if bus();

  vga_pattern_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .CBITS(2), .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (bus),
    .hs         (hs),
    .vs         (vs),
    .de         (de),
    .rgb        (rgb),
    .frame_tick (ft)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic h_, input logic v_, input logic d_,
                                       input logic f_, input logic [5:0] c_);
    return {22'd0, h_, v_, d_, f_, c_};
  endfunction

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference model state: raster position, noise register, registers by address.
  int          m_h = 0, m_v = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_pend[4] = '{0, 0, 0, 3};
  int          m_act[4]  = '{0, 0, 0, 3};

  typedef struct {
    int          h;
    int          v;
    bit          in_rst;
    logic [31:0] bits;
  } exp_t;
  exp_t sb[$];

  // Most recent sample and one captured frame of DUT outputs.
  int   s_h, s_v;
  logic s_ft;
  logic fb_hs[FRAME];
  logic fb_vs[FRAME];
  logic fb_de[FRAME];
  logic [5:0] fb_rgb[FRAME];

  task automatic model_push();
    exp_t e;
    bit act, hsa, vsa, cm;
    logic [5:0] px;
    int g;
    e.h = m_h; e.v = m_v; e.in_rst = rst;
    if (rst) begin
      e.bits = pack(1'b1, 1'b1, 1'b0, 1'b0, 6'h00);
      m_h = 0; m_v = 0; m_lfsr = 16'hACE1;
      m_pend = '{0, 0, 0, 3};
      m_act  = '{0, 0, 0, 3};
    end else begin
      act = (m_h < HA) && (m_v < VA);
      hsa = (m_h >= HA + HF) && (m_h < HA + HF + HSY);
      vsa = (m_v >= VA + VF) && (m_v < VA + VF + VSY);
      cm  = (m_h == HT - 1) && (m_v == VT - 1);
      px  = 6'h00;
      if (act) begin
        case (m_act[0])
          0: px = 6'(m_act[1]);
          1: px = m_lfsr[5:0];
          2: px = ((((m_h >> m_act[3]) ^ (m_v >> m_act[3])) & 1) != 0) ? 6'(m_act[1]) : 6'(m_act[2]);
          default: begin
            g  = (m_h >> m_act[3]) & 3;
            px = 6'(g * 21);
          end
        endcase
      end
      e.bits = pack(!hsa, !vsa, act, cm, px);
      if (act) m_lfsr = step(m_lfsr);
      if (cm) m_act = m_pend;
      if (bus.cfg_wr) begin
        case (bus.cfg_addr)
          2'd0:    m_pend[0] = int'(bus.cfg_data & 12'h003);
          2'd3:    m_pend[3] = int'(bus.cfg_data & 12'h007);
          default: m_pend[bus.cfg_addr] = int'(bus.cfg_data & 12'h03F);
        endcase
      end
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    int t;
    @(posedge clk);
    model_push();
    @(negedge clk);
    e = sb.pop_front();
    s_h = e.h; s_v = e.v; s_ft = ft;
    check("cycle", pack(hs, vs, de, ft, rgb), e.bits);
    if (!e.in_rst) begin
      t = e.v * HT + e.h;
      fb_hs[t] = hs; fb_vs[t] = vs; fb_de[t] = de; fb_rgb[t] = rgb;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [11:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  // Advance until the next tick processes raster position (h,v).
  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v) && n <= FRAME + 2) begin
      tick();
      n++;
    end
    if (!(m_h == h && m_v == v)) check("run_to_timeout", 32'd0, 32'd1);
  endtask

  task automatic commit_frame();
    run_to(HT - 1, VT - 1);
    tick();
    check("frame_tick", 32'(s_ft), 32'd1);
  endtask

  task automatic run_frame();
    for (int i = 0; i < FRAME; i++) tick();
  endtask

  function automatic int count_rgb(input logic [5:0] val);
    int c;
    c = 0;
    for (int t = 0; t < FRAME; t++) if (fb_de[t] && fb_rgb[t] == val) c++;
    return c;
  endfunction

  int cnt_de, cnt_hs_low, cnt_vs_low, falls, p1, p2, nz, n_ft, got;
  logic [15:0] l;

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_data = 12'd0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_out", pack(hs, vs, de, ft, rgb), pack(1'b1, 1'b1, 1'b0, 1'b0, 6'h00));
    rst = 1'b0;

    // Raster geometry over one full frame.
    run_frame();
    cnt_de = 0; cnt_hs_low = 0; cnt_vs_low = 0; falls = 0; p1 = -1; p2 = -1;
    for (int t = 0; t < FRAME; t++) begin
      if (fb_de[t]) cnt_de++;
      if (!fb_hs[t]) cnt_hs_low++;
      if (!fb_vs[t]) cnt_vs_low++;
      if (fb_hs[(t + FRAME - 1) % FRAME] && !fb_hs[t]) begin
        falls++;
        if (p1 < 0) p1 = t; else if (p2 < 0) p2 = t;
      end
    end
    check("de_count", 32'(cnt_de), 32'(HA * VA));
    check("hs_low_clocks", 32'(cnt_hs_low), 32'(HSY * VT));
    check("lines_per_frame", 32'(falls), 32'(VT));
    check("clocks_per_line", 32'(p2 - p1), 32'(HT));
    check("vs_low_clocks", 32'(cnt_vs_low), 32'(VSY * HT));
    check("vs_start", {30'd0, fb_vs[(VA + VF - 1) * HT + HT - 1], fb_vs[(VA + VF) * HT]}, 32'b10);
    check("hs_start", {30'd0, fb_hs[HA + HF - 1], fb_hs[HA + HF]}, 32'b10);

    // Mid-frame writes must not show before the commit.
    run_to(5, 3);
    cfg_write(2'd0, 12'h000);
    cfg_write(2'd1, 12'h03F);
    nz = 0; got = 0;
    for (int i = 0; i < 2 * FRAME && got == 0; i++) begin
      tick();
      if (s_ft) got = 1;
      else if (de && rgb != 6'h00) nz++;
    end
    check("commit_seen", 32'(got), 32'd1);
    check("pre_commit_rgb", 32'(nz), 32'd0);
    run_frame();
    check("solid_fg", 32'(count_rgb(6'h3F)), 32'(HA * VA));

    // Write on the commit cycle itself takes effect one frame later.
    run_to(HT - 1, VT - 1);
    cfg_write(2'd1, 12'h015);
    check("collision_tick", 32'(s_ft), 32'd1);
    run_frame();
    check("collision_old", 32'(count_rgb(6'h3F)), 32'(HA * VA));
    run_frame();
    check("collision_new", 32'(count_rgb(6'h15)), 32'(HA * VA));

    // Checkerboard, 8-pixel cells.
    cfg_write(2'd0, 12'h002);
    cfg_write(2'd3, 12'h003);
    cfg_write(2'd1, 12'h03F);
    cfg_write(2'd2, 12'h000);
    commit_frame();
    run_frame();
    check("chk_0_0", 32'(fb_rgb[0]), 32'h00);
    check("chk_8_0", 32'(fb_rgb[8]), 32'h3F);
    check("chk_8_8", 32'(fb_rgb[8 * HT + 8]), 32'h00);
    check("chk_0_8", 32'(fb_rgb[8 * HT]), 32'h3F);

    // Gradient and blanking.
    cfg_write(2'd0, 12'h003);
    cfg_write(2'd3, 12'h000);
    commit_frame();
    run_frame();
    check("grad_x5", 32'(fb_rgb[5]), 32'h15);
    check("grad_x3", 32'(fb_rgb[3]), 32'h3F);
    check("blank_hsync", 32'(fb_rgb[HA + HF + 1]), 32'h00);
    check("blank_vert", 32'(fb_rgb[VA * HT + 5]), 32'h00);

    // Noise mode, then a one-cycle reset in the middle of a line.
    cfg_write(2'd0, 12'h001);
    commit_frame();
    run_to(10, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out", pack(hs, vs, de, ft, rgb), pack(1'b1, 1'b1, 1'b0, 1'b0, 6'h00));
    n_ft = 0; got = 0;
    for (int i = 1; i <= 2 * FRAME && got == 0; i++) begin
      if (i == 20) begin
        bus.cfg_wr = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 12'h001;
      end
      tick();
      bus.cfg_wr = 1'b0;
      if (i == 1) check("restart_00", pack(hs, vs, de, ft, rgb), pack(1'b1, 1'b1, 1'b1, 1'b0, 6'h00));
      if (s_ft) begin
        got = 1;
        n_ft = i;
      end
    end
    check("frame_after_rst", 32'(n_ft), 32'(FRAME));
    run_frame();
    for (int k = 0; k < 4; k++) begin
      l = 16'hACE1;
      for (int i = 0; i < HA * VA + k; i++) l = step(l);
      check("noise_restart", 32'(fb_rgb[k]), 32'(l[5:0]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_pattern_engine.md
VGA_PATTERN_ENGINE -- requirements
Module: vga_pattern_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter CBITS, default 2, range 1..4, bits per colour channel.
REQ-006 SHALL have parameter SYNC_POL, default 0, asserted level of hs/vs.
REQ-007 SHALL have port clk, input, 1, the single clock; synchronous, active-high reset is already decided.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port cfg_wr, input, 1, write strobe for config registers.
REQ-010 SHALL have port cfg_addr, input, 2, config register select.
REQ-011 SHALL have port cfg_data, input, 12, write data; low bits used per register.
REQ-012 SHALL have ports hs and vs, output, 1 each, sync outputs.
REQ-013 SHALL have port de, output, 1, active-video flag.
REQ-014 SHALL have port rgb, output, 3*CBITS, {red,green,blue}, zero outside active video.
REQ-015 SHALL have port frame_tick, output, 1, one-cycle pulse marking config commit.

Function
REQ-016 SHALL run hcount 0..H_TOTAL-1 (H_TOTAL = sum of horizontal parameters), wrapping to 0 and incrementing vcount, which wraps at V_TOTAL-1.
REQ-017 SHALL assert hs for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs likewise on vcount.
REQ-018 SHALL define active as hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-019 SHALL register hs, vs, de and rgb together: exactly 1 cycle latency from counter state to outputs.
REQ-020 SHALL hold pending registers: addr0 mode[1:0], addr1 fg[3*CBITS-1:0], addr2 bg[3*CBITS-1:0], addr3 shift[2:0]; cfg_wr writes pending[cfg_addr] on that clock.
REQ-021 SHALL copy all pending registers into active registers atomically on the cycle where hcount==H_TOTAL-1 and vcount==V_TOTAL-1, and assert frame_tick that cycle (registered, visible next cycle).
REQ-022 SHALL, on a cfg_wr coinciding with the commit cycle, commit the old pending value and apply the new write to pending only (takes effect next frame).
REQ-023 SHALL, in mode 0 (solid), output fg.
REQ-024 SHALL, in mode 1 (noise), output LFSR[3*CBITS-1:0]; 16-bit Fibonacci LFSR, taps 16,14,13,11, advances only on active cycles.
REQ-025 SHALL, in mode 2 (checker), output fg when bit0 of ((hcount>>shift) XOR (vcount>>shift)) is 1, else bg.
REQ-026 SHALL, in mode 3 (gradient), output (hcount>>shift) truncated to CBITS, replicated on all three channels.
REQ-027 SHALL force rgb to 0 when not active, regardless of mode.

Reset
REQ-028 SHALL, on rst, set hcount=0, vcount=0, LFSR=16'hACE1, pending and active mode=0, fg=0, bg=0, shift=3.
REQ-029 SHALL, on rst, drive hs=vs=~SYNC_POL, de=0, rgb=0, frame_tick=0 from the next edge.
REQ-030 SHALL, when rst is asserted mid-frame, restart timing from (0,0) and discard pending writes.

Structure
REQ-031 SHALL place mode encodings, register addresses and reset constants (seed, default shift) in a shared package vga_pkg.
REQ-032 SHALL contain one sub-module vga_timing_core (counters, sync, active, commit strobe); pattern logic and registers remain in the top.

Verification
REQ-033 SHALL check defaults: one frame after reset -> 800 clocks/line, 525 lines/frame, hs low 96 clocks, vs low 2 lines, de high 640x480.
REQ-034 SHALL check deferred commit: mid-frame write mode=0, fg=0x3F -> rgb stays 0 until after frame_tick, then 0x3F on every active pixel.
REQ-035 SHALL check collision: cfg_wr of fg=0x15 on the commit cycle -> current frame keeps old fg; 0x15 appears one frame later.
REQ-036 SHALL check checker: mode=2, shift=3, fg=0x3F, bg=0x00 -> pixel (0,0)=0x00, (8,0)=0x3F, (8,8)=0x00.
REQ-037 SHALL check gradient and blanking: mode=3, shift=0, CBITS=2 -> pixel x=5 gives 0x15; hcount=700 gives rgb=0.
REQ-038 SHALL check reset mid-line: rst for 1 cycle at hcount=300 -> outputs at reset values next cycle, counters restart at 0, noise sequence restarts from 16'hACE1.
